ddr3_cmd_gen: RTL and testbench

// - Downstream end of the bank FSM command interface; one instance, shared by both bank FSMs.
// - Accepts ACTIVATE/READ/WRITE/PRECHARGE from the 2 ddr3_bank_fsm instances and arbitrates them round-robin.
// - Enforces inter-bank timing (tRRD, tCCD, tWTR) and drives the registered DDR3 command/address pins.
// - Per-bank timing (tRCD, tRAS, tRP) remains owned by the bank FSMs.

---
 rtl/ddr3_cmd_gen_pkg.sv | 37 +++
 rtl/ddr3_timing_cnt.sv | 34 +++
 rtl/ddr3_cmd_gen.sv | 149 ++++++++++++++
 tb/tb_ddr3_cmd_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_cmd_gen_pkg.sv
// Shared DDR3 definitions for the command generator: command types, pin
// encodings and address widths.
package ddr3_cmd_gen_pkg;

  localparam int ROW_BITS   = 14;
  localparam int COL_BITS   = 10;
  localparam int ADDR_WIDTH = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS;
  localparam int BANK_BITS  = 3;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_ACTIVATE   = 3'd1,
    CMD_READ       = 3'd2,
    CMD_WRITE      = 3'd3,
    CMD_PRECHARGE  = 3'd4,
    CMD_ACTIVATING = 3'd5
  } ddr3_cmd_t;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } ddr3_pin_t;

  localparam ddr3_pin_t DDR3_PIN_DES = 4'b1111;
  localparam ddr3_pin_t DDR3_PIN_ACT = 4'b0011;
  localparam ddr3_pin_t DDR3_PIN_RD  = 4'b0101;
  localparam ddr3_pin_t DDR3_PIN_WR  = 4'b0100;
  localparam ddr3_pin_t DDR3_PIN_PRE = 4'b0010;

  // Counter width for a minimum spacing of t cycles; it must hold t-1.
  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/ddr3_timing_cnt.sv
// Load/decrement/saturate spacing counter; zero=1 means the constraint is met.
module ddr3_timing_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ddr3_cmd_gen.sv
// Two-bank DDR3 command arbiter: round-robin grant, inter-bank spacing
// (tRRD/tCCD/tWTR) and registered command/address pins.
module ddr3_cmd_gen
  import ddr3_cmd_gen_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int T_RRD     = 4,
  parameter int T_CCD     = 4,
  parameter int T_WTR     = 10
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_BANKS-1:0]                 cmd_valid,
  input  ddr3_cmd_t [NUM_BANKS-1:0]            cmd_type,
  input  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] cmd_addr,
  output logic [NUM_BANKS-1:0]                 cmd_ready,
  output logic                                 ddr_cs_n,
  output logic                                 ddr_ras_n,
  output logic                                 ddr_cas_n,
  output logic                                 ddr_we_n,
  output logic [BANK_BITS-1:0]                 ddr_ba,
  output logic [ADDR_WIDTH-1:0]                ddr_addr,
  output logic                                 issued,
  output logic                                 cmd_err
);

  localparam int RRD_W = cnt_width(T_RRD);
  localparam int CCD_W = cnt_width(T_CCD);
  localparam int WTR_W = cnt_width(T_WTR);
  localparam logic [RRD_W-1:0] RRD_LOAD = RRD_W'(T_RRD - 1);
  localparam logic [CCD_W-1:0] CCD_LOAD = CCD_W'(T_CCD - 1);
  localparam logic [WTR_W-1:0] WTR_LOAD = WTR_W'(T_WTR - 1);

  logic                  en_q, en_d;
  logic                  last_grant_q, last_grant_d;
  ddr3_pin_t             pins_q, pins_d;
  logic [BANK_BITS-1:0]  ba_q, ba_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  issued_q, issued_d;
  logic                  err_q, err_d;

  logic                  rrd_zero, ccd_zero, wtr_zero;
  logic                  load_rrd, load_ccd, load_wtr;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  any_grant;
  logic                  grant_idx;
  ddr3_cmd_t             sel_type;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  supported;

  function automatic logic type_ok(input ddr3_cmd_t t, input logic rrd_ok,
                                   input logic ccd_ok, input logic wtr_ok);
    case (t)
      CMD_ACTIVATE: return rrd_ok;
      CMD_READ:     return ccd_ok & wtr_ok;
      CMD_WRITE:    return ccd_ok;
      default:      return 1'b1;
    endcase
  endfunction

  ddr3_timing_cnt #(.WIDTH(RRD_W)) u_rrd_cnt (
    .clk(clk), .rst_n(rst_n), .load(load_rrd), .load_val(RRD_LOAD), .zero(rrd_zero)
  );
  ddr3_timing_cnt #(.WIDTH(CCD_W)) u_ccd_cnt (
    .clk(clk), .rst_n(rst_n), .load(load_ccd), .load_val(CCD_LOAD), .zero(ccd_zero)
  );
  ddr3_timing_cnt #(.WIDTH(WTR_W)) u_wtr_cnt (
    .clk(clk), .rst_n(rst_n), .load(load_wtr), .load_val(WTR_LOAD), .zero(wtr_zero)
  );

  // Unsupported types are granted like PRE so a confused bank cannot stall.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = en_q & cmd_valid[i] & type_ok(cmd_type[i], rrd_zero, ccd_zero, wtr_zero);
    end

    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
    any_grant = |grant;
    grant_idx = grant[1];
    sel_type  = cmd_type[grant_idx];
    sel_addr  = cmd_addr[grant_idx];

    pins_d    = DDR3_PIN_DES;
    ba_d      = '0;
    addr_d    = '0;
    issued_d  = 1'b0;
    err_d     = 1'b0;
    supported = 1'b1;
    case (sel_type)
      CMD_ACTIVATE:  pins_d = DDR3_PIN_ACT;
      CMD_READ:      pins_d = DDR3_PIN_RD;
      CMD_WRITE:     pins_d = DDR3_PIN_WR;
      CMD_PRECHARGE: pins_d = DDR3_PIN_PRE;
      default:       supported = 1'b0;
    endcase
    if (!any_grant) begin
      pins_d = DDR3_PIN_DES;
    end else if (supported) begin
      issued_d = 1'b1;
      ba_d     = BANK_BITS'(grant_idx);
      addr_d   = sel_addr;
    end else begin
      err_d = 1'b1;
    end

    load_rrd     = any_grant & (sel_type == CMD_ACTIVATE);
    load_ccd     = any_grant & ((sel_type == CMD_READ) | (sel_type == CMD_WRITE));
    load_wtr     = any_grant & (sel_type == CMD_WRITE);
    last_grant_d = any_grant ? grant_idx : last_grant_q;
    en_d         = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q         <= 1'b0;
      last_grant_q <= 1'b1;
      pins_q       <= DDR3_PIN_DES;
      ba_q         <= '0;
      addr_q       <= '0;
      issued_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      last_grant_q <= last_grant_d;
      pins_q       <= pins_d;
      ba_q         <= ba_d;
      addr_q       <= addr_d;
      issued_q     <= issued_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready = grant;
  assign ddr_cs_n  = pins_q.cs_n;
  assign ddr_ras_n = pins_q.ras_n;
  assign ddr_cas_n = pins_q.cas_n;
  assign ddr_we_n  = pins_q.we_n;
  assign ddr_ba    = ba_q;
  assign ddr_addr  = addr_q;
  assign issued    = issued_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_ddr3_cmd_gen.sv
// Directed bench for ddr3_cmd_gen: reset, single ACT, tRRD collision,
// non-blocking arbitration, tWTR, round-robin reads, dropped commands, mid-run reset.
module tb_ddr3_cmd_gen;
  import ddr3_cmd_gen_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic [1:0]                 cmd_valid;
  ddr3_cmd_t [1:0]            cmd_type;
  logic [1:0][ADDR_WIDTH-1:0] cmd_addr;
  logic [1:0]                 cmd_ready;
  logic                       ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
  logic [BANK_BITS-1:0]       ddr_ba;
  logic [ADDR_WIDTH-1:0]      ddr_addr;
  logic                       issued;
  logic                       cmd_err;

  int checks = 0;
  int errors = 0;

  ddr3_cmd_gen #(
    .NUM_BANKS(2), .T_RRD(4), .T_CCD(4), .T_WTR(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
    .cmd_ready(cmd_ready),
    .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
    .ddr_ba(ddr_ba), .ddr_addr(ddr_addr), .issued(issued), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input ddr3_cmd_t t0, input logic [ADDR_WIDTH-1:0] a0,
                               input ddr3_cmd_t t1, input logic [ADDR_WIDTH-1:0] a1);
    cmd_valid   = v;
    cmd_type[0] = t0;
    cmd_addr[0] = a0;
    cmd_type[1] = t1;
    cmd_addr[1] = a1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkPins(input string tag, input logic [3:0] p, input logic [2:0] ba,
                           input logic [ADDR_WIDTH-1:0] addr, input logic iss, input logic err);
    checkOutput({tag, "_pins"}, 32'({ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}), 32'(p));
    checkOutput({tag, "_ba"}, 32'(ddr_ba), 32'(ba));
    checkOutput({tag, "_addr"}, 32'(ddr_addr), 32'(addr));
    checkOutput({tag, "_issued"}, 32'(issued), 32'(iss));
    checkOutput({tag, "_err"}, 32'(cmd_err), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b01, CMD_ACTIVATE, 14'h0123, CMD_NOP, 14'h0000);
    repeat (2) tick();
    checkPins("reset", 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b0);
    checkOutput("reset_ready", 32'(cmd_ready), 32'h0);

    rst_n = 1'b1;
    #1;
    checkOutput("release_ready", 32'(cmd_ready), 32'h0);

    // Single ACT from bank 0, then bank 1 PRE slips past a tRRD-blocked ACT.
    tick();
    applyStimulus(2'b01, CMD_ACTIVATE, 14'h0123, CMD_NOP, 14'h0000);
    checkOutput("single_act_ready", 32'(cmd_ready), 32'h1);
    checkPins("pre_grant_des", 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b0);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0AAA, CMD_PRECHARGE, 14'h0000);
    checkPins("single_act", 4'b0011, 3'd0, 14'h0123, 1'b1, 1'b0);
    checkOutput("nonblock_ready", 32'(cmd_ready), 32'h2);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0AAA, CMD_ACTIVATE, 14'h1555);
    checkPins("nonblock_pre", 4'b0010, 3'd1, 14'h0000, 1'b1, 1'b0);
    checkOutput("rrd_hold_a", 32'(cmd_ready), 32'h0);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0AAA, CMD_ACTIVATE, 14'h1555);
    checkPins("des_after_pre", 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b0);
    checkOutput("rrd_hold_b", 32'(cmd_ready), 32'h0);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0AAA, CMD_ACTIVATE, 14'h1555);
    checkOutput("collision_b0", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_ACTIVATE, 14'h1555);
    checkPins("collision_b0_pins", 4'b0011, 3'd0, 14'h0AAA, 1'b1, 1'b0);
    checkOutput("collision_hold_1", 32'(cmd_ready), 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_ACTIVATE, 14'h1555);
      checkOutput("collision_hold_n", 32'(cmd_ready), 32'h0);
    end
    tick();
    applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_ACTIVATE, 14'h1555);
    checkOutput("collision_b1", 32'(cmd_ready), 32'h2);

    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("collision_b1_pins", 4'b0011, 3'd1, 14'h1555, 1'b1, 1'b0);

    // WR on bank 0 holds off a bank 1 RD for ten cycles.
    tick();
    applyStimulus(2'b01, CMD_WRITE, 14'h0040, CMD_NOP, 14'h0000);
    checkOutput("wr_ready", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_READ, 14'h0080);
    checkPins("wr_pins", 4'b0100, 3'd0, 14'h0040, 1'b1, 1'b0);
    checkOutput("wtr_hold_1", 32'(cmd_ready), 32'h0);
    for (int k = 2; k < 10; k++) begin
      tick();
      applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_READ, 14'h0080);
      checkOutput($sformatf("wtr_hold_%0d", k), 32'(cmd_ready), 32'h0);
    end
    tick();
    applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_READ, 14'h0080);
    checkOutput("wtr_release", 32'(cmd_ready), 32'h2);

    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("rd_pins", 4'b0101, 3'd1, 14'h0080, 1'b1, 1'b0);
    repeat (2) begin
      tick();
      applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    end

    // Continuous reads from both banks alternate every tCCD.
    for (int k = 0; k < 13; k++) begin
      tick();
      applyStimulus(2'b11, CMD_READ, 14'h0100, CMD_READ, 14'h0200);
      if (k % 4 == 0) begin
        checkOutput($sformatf("rr_grant_%0d", k), 32'(cmd_ready),
                    ((k / 4) % 2 == 0) ? 32'h1 : 32'h2);
      end else begin
        checkOutput($sformatf("rr_idle_%0d", k), 32'(cmd_ready), 32'h0);
      end
      if (k % 4 == 1) begin
        checkPins($sformatf("rr_pins_%0d", k), 4'b0101, 3'(((k - 1) / 4) % 2),
                  (((k - 1) / 4) % 2 == 0) ? 14'h0100 : 14'h0200, 1'b1, 1'b0);
      end
    end
    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("rr_last_pins", 4'b0101, 3'd1, 14'h0200, 1'b1, 1'b0);

    // Unsupported type is accepted and dropped, then back-to-back PREs.
    tick();
    applyStimulus(2'b01, CMD_NOP, 14'h0777, CMD_NOP, 14'h0000);
    checkOutput("nop_ready", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("nop_dropped", 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b1);

    tick();
    applyStimulus(2'b01, CMD_PRECHARGE, 14'h0000, CMD_NOP, 14'h0000);
    checkOutput("err_cleared", 32'(cmd_err), 32'h0);
    checkOutput("b2b_pre0_ready", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b10, CMD_NOP, 14'h0000, CMD_PRECHARGE, 14'h0000);
    checkPins("b2b_pre0", 4'b0010, 3'd0, 14'h0000, 1'b1, 1'b0);
    checkOutput("b2b_pre1_ready", 32'(cmd_ready), 32'h2);

    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("b2b_pre1", 4'b0010, 3'd1, 14'h0000, 1'b1, 1'b0);

    // Reset asserted while an ACT is on the pins.
    tick();
    applyStimulus(2'b01, CMD_ACTIVATE, 14'h0200, CMD_NOP, 14'h0000);
    checkOutput("mid_act_ready", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0300, CMD_ACTIVATE, 14'h0400);
    checkPins("mid_act_pins", 4'b0011, 3'd0, 14'h0200, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkPins("mid_reset", 4'b1111, 3'd0, 14'h0000, 1'b0, 1'b0);
    checkOutput("mid_reset_ready", 32'(cmd_ready), 32'h0);

    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_en", 32'(cmd_ready), 32'h0);

    tick();
    applyStimulus(2'b11, CMD_ACTIVATE, 14'h0300, CMD_ACTIVATE, 14'h0400);
    checkOutput("post_reset_ready", 32'(cmd_ready), 32'h1);

    tick();
    applyStimulus(2'b00, CMD_NOP, 14'h0000, CMD_NOP, 14'h0000);
    checkPins("post_reset_act", 4'b0011, 3'd0, 14'h0300, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
